// File: rtl/axi_sram_slave_if.sv
// AXI4 single-beat bus bundle between the core's master port and the SRAM slave model.
interface axi_sram_slave_if;
  logic        awready;
  logic        awvalid;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic        wready;
  logic        wvalid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arready;
  logic        arvalid;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  modport slave (
    output awready, wready, bvalid, bresp, bid,
    output arready, rvalid, rdata, rresp, rlast, rid,
    input  awvalid, awaddr, awid, awlen, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arid, arlen, rready
  );

  modport master (
    input  awready, wready, bvalid, bresp, bid,
    input  arready, rvalid, rdata, rresp, rlast, rid,
    output awvalid, awaddr, awid, awlen, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arid, arlen, rready
  );
endinterface

// File: rtl/axi_sram_slave.sv
// Single-port AXI4 SRAM slave, one single-beat transaction in flight, programmable latencies.
// Define AXI_SRAM_RAND_DELAY_EN to draw per-transaction latencies (0..7) from an 8-bit LFSR.
module axi_sram_slave #(
  parameter logic [31:0] MEM_BASE   = 32'h8000_0000,
  parameter int unsigned MEM_WORDS  = 4096,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned WR_LATENCY = 1,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input logic             clock,
  input logic             reset,
  axi_sram_slave_if.slave bus
);
  localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_DATA, WR_WAIT, WR_RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  id_q, id_d;
  logic        len_err_q, len_err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [1:0]  bresp_q, bresp_d;

  logic [31:0]      mem [MEM_WORDS];
  logic [32:0]      offset;
  logic             dec_err;
  logic [1:0]       access_resp;
  logic [IDX_W-1:0] widx;
  logic             mem_we;
  logic [7:0]       rd_lat;
  logic [7:0]       wr_lat;

`ifdef AXI_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign rd_lat = {5'd0, lfsr_q[2:0]};
  assign wr_lat = {5'd0, lfsr_q[2:0]};
`else
  assign rd_lat = 8'(RD_LATENCY);
  assign wr_lat = 8'(WR_LATENCY);
`endif

  // 33-bit subtraction: the borrow bit flags addresses below MEM_BASE
  assign offset      = {1'b0, addr_q} - {1'b0, MEM_BASE};
  assign dec_err     = offset[32] || (offset >= MEM_BYTES);
  assign widx        = offset[IDX_W+1:2];
  assign access_resp = dec_err ? RESP_DECERR : (len_err_q ? RESP_SLVERR : RESP_OKAY);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    id_d        = id_q;
    len_err_d   = len_err_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    bresp_d     = bresp_q;
    mem_we      = 1'b0;
    bus.arready = 1'b0;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.rvalid  = 1'b0;
    bus.bvalid  = 1'b0;
    case (state_q)
      IDLE: begin
        // Readies are gated by reset so they read 0 while reset is held
        bus.arready = reset;
        bus.awready = reset && !bus.arvalid;
        if (bus.arvalid) begin
          addr_d    = bus.araddr;
          id_d      = bus.arid;
          len_err_d = |bus.arlen;
          cnt_d     = rd_lat;
          state_d   = RD_WAIT;
        end else if (bus.awvalid) begin
          addr_d    = bus.awaddr;
          id_d      = bus.awid;
          len_err_d = |bus.awlen;
          state_d   = WR_DATA;
        end
      end
      RD_WAIT: begin
        if (cnt_q == 8'd0) begin
          rdata_d = dec_err ? 32'd0 : mem[widx];
          rresp_d = access_resp;
          state_d = RD_RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RD_RESP: begin
        bus.rvalid = 1'b1;
        if (bus.rready) state_d = IDLE;
      end
      WR_DATA: begin
        bus.wready = 1'b1;
        if (bus.wvalid) begin
          mem_we  = (access_resp == RESP_OKAY);
          bresp_d = access_resp;
          cnt_d   = wr_lat;
          state_d = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (cnt_q == 8'd0) state_d = WR_RESP;
        else               cnt_d   = cnt_q - 8'd1;
      end
      WR_RESP: begin
        bus.bvalid = 1'b1;
        if (bus.bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= 32'd0;
      id_q      <= 4'd0;
      len_err_q <= 1'b0;
      cnt_q     <= 8'd0;
      rdata_q   <= 32'd0;
      rresp_q   <= 2'b00;
      bresp_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      id_q      <= id_d;
      len_err_q <= len_err_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      bresp_q   <= bresp_d;
    end
  end

  // Storage is deliberately outside the reset domain: contents survive reset
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) mem[widx][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.rresp = rresp_q;
  assign bus.rlast = bus.rvalid;
  assign bus.rid   = id_q;
  assign bus.bresp = bresp_q;
  assign bus.bid   = id_q;
endmodule
